// File: rtl/inert_pkg.sv
// inert_pkg: sequencer state encoding and iNEMO gyro command words.
package inert_pkg;

    typedef enum logic [3:0] {
        PWR, CFG1, CFG2, CFG3, IDLE, RDL, RDH, VLD, HOLD
    } seq_state_t;

    localparam logic [15:0] CMD_INT_EN   = 16'h0D02;
    localparam logic [15:0] CMD_GYRO_ODR = 16'h1160;
    localparam logic [15:0] CMD_ROUND    = 16'h1440;
    localparam logic [15:0] CMD_YAWL     = 16'hA600;
    localparam logic [15:0] CMD_YAWH     = 16'hA700;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer with asynchronous reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic ff1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= 1'b0;
            q     <= 1'b0;
        end else begin
            ff1_q <= d;
            q     <= ff1_q;
        end
    end

endmodule

// File: rtl/inert_spi_seq.sv
// inert_spi_seq: gyro power-up/config sequencer and interrupt-driven yaw-rate reader
// driving the SPI monarch wrt/cmd handshake.
module inert_spi_seq
    import inert_pkg::*;
#(
    parameter int PWR_W    = 16,
    parameter int HOLD_CYC = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] yaw_rt,
    output logic        vld,
    output logic        setup_done
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    seq_state_t       state_q, state_d;
    logic [PWR_W-1:0] tmr_q, tmr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [7:0]       lo_q, lo_d;
    logic [15:0]      cmd_q, cmd_d, yaw_q, yaw_d;
    logic             wrt_q, wrt_d, vld_q, vld_d, setup_q, setup_d;
    logic             int_ff2, fin, unused_hi;

    sync2 u_int_sync (.clk(clk), .rst_n(rst_n), .d(INT), .q(int_ff2));

    // a done that coincides with a fresh wrt belongs to the previous transfer
    assign fin       = done && !wrt_q;
    assign unused_hi = ^rd_data[15:8];

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        hold_d  = hold_q;
        lo_d    = lo_q;
        cmd_d   = cmd_q;
        yaw_d   = yaw_q;
        setup_d = setup_q;
        wrt_d   = 1'b0;
        vld_d   = 1'b0;
        case (state_q)
            PWR: begin
                tmr_d = tmr_q + 1'b1;
                if (&tmr_d) begin
                    wrt_d   = 1'b1;
                    cmd_d   = CMD_INT_EN;
                    state_d = CFG1;
                end
            end
            CFG1: if (fin) begin
                wrt_d   = 1'b1;
                cmd_d   = CMD_GYRO_ODR;
                state_d = CFG2;
            end
            CFG2: if (fin) begin
                wrt_d   = 1'b1;
                cmd_d   = CMD_ROUND;
                state_d = CFG3;
            end
            CFG3: if (fin) begin
                setup_d = 1'b1;
                state_d = IDLE;
            end
            IDLE: if (int_ff2) begin
                wrt_d   = 1'b1;
                cmd_d   = CMD_YAWL;
                state_d = RDL;
            end
            RDL: if (fin) begin
                lo_d    = rd_data[7:0];
                wrt_d   = 1'b1;
                cmd_d   = CMD_YAWH;
                state_d = RDH;
            end
            RDH: if (fin) begin
                yaw_d   = {rd_data[7:0], lo_q};
                vld_d   = 1'b1;
                state_d = VLD;
            end
            VLD: begin
                hold_d  = HW'(HOLD_CYC);
                state_d = HOLD;
            end
            HOLD: begin
                // masks INT while its deassertion crawls through the synchronizer
                if (hold_q <= HW'(1)) state_d = IDLE;
                else hold_d = hold_q - 1'b1;
            end
            default: state_d = PWR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PWR;
            tmr_q   <= '0;
            hold_q  <= '0;
            lo_q    <= '0;
            cmd_q   <= '0;
            yaw_q   <= '0;
            wrt_q   <= 1'b0;
            vld_q   <= 1'b0;
            setup_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            hold_q  <= hold_d;
            lo_q    <= lo_d;
            cmd_q   <= cmd_d;
            yaw_q   <= yaw_d;
            wrt_q   <= wrt_d;
            vld_q   <= vld_d;
            setup_q <= setup_d;
        end
    end

    assign wrt        = wrt_q;
    assign cmd        = cmd_q;
    assign yaw_rt     = yaw_q;
    assign vld        = vld_q;
    assign setup_done = setup_q;

endmodule

// File: tb/tb_inert_spi_seq.sv
// tb_inert_spi_seq: scoreboard bench with a 40-cycle SPI monarch model for inert_spi_seq.
module tb_inert_spi_seq;
    import inert_pkg::*;

    localparam int HOLD = 3;

    logic        clk = 0, rst_n = 0, INT = 0, model_done = 0, spur_done = 0, done;
    logic [15:0] rd_data = 16'h0, cmd, yaw_rt;
    logic        wrt, vld, setup_done;
    int          checks = 0, errors = 0, cyc = 0, rel = 0, ic = 0, nw = 0, nv = 0;
    int          setup_cyc = -1, cnt = 0;
    logic        busy = 0, wrt_prev = 0, vld_prev = 0, setup_prev = 0;
    logic [15:0] busy_cmd = 16'h0;
    logic [15:0] exp_cmd[$], exp_yaw[$];
    logic [7:0]  rdq[$];
    int          wrt_log[$], vld_log[$];

    assign done = model_done | spur_done;

    inert_spi_seq #(.PWR_W(8), .HOLD_CYC(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
        .wrt(wrt), .cmd(cmd), .yaw_rt(yaw_rt), .vld(vld), .setup_done(setup_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cnt(input string tag, input int n_wrt, input int n_vld, input int budget);
        for (int i = 0; i < budget && (wrt_log.size() < n_wrt || vld_log.size() < n_vld); i++) tick();
        check(tag, (wrt_log.size() >= n_wrt && vld_log.size() >= n_vld), 1);
    endtask

    task automatic wait_setup(input string tag);
        for (int i = 0; i < 200 && setup_cyc < 0; i++) tick();
        check(tag, setup_cyc >= 0, 1);
    endtask

    task automatic pulse_done();
        spur_done = 1;
        tick();
        spur_done = 0;
    endtask

    // SPI monarch: done is sampled by the DUT 40 clocks after the wrt edge
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 0;
            cnt = 0;
            model_done = 0;
        end else begin
            model_done = 0;
            if (busy) begin
                cnt--;
                if (cnt == 1) begin
                    busy = 0;
                    model_done = 1;
                    check("cmd_hold", cmd, busy_cmd);
                    if (busy_cmd == CMD_YAWL || busy_cmd == CMD_YAWH) begin
                        check("rdq_avail", rdq.size() > 0, 1);
                        rd_data = {8'hA5, (rdq.size() > 0) ? rdq.pop_front() : 8'h00};
                    end else rd_data = 16'hFFFF;
                end
            end
            if (wrt && !busy) begin
                busy = 1;
                cnt = 40;
                busy_cmd = cmd;
            end
        end
    end

    always @(negedge clk) begin
        if (wrt) begin
            wrt_log.push_back(cyc);
            check("wrt_width", wrt_prev, 0);
            check("wrt_pending", exp_cmd.size() > 0, 1);
            if (exp_cmd.size() > 0) check("cmd", cmd, exp_cmd.pop_front());
        end
        if (vld) begin
            vld_log.push_back(cyc);
            check("vld_width", vld_prev, 0);
            check("vld_pending", exp_yaw.size() > 0, 1);
            if (exp_yaw.size() > 0) check("yaw", yaw_rt, exp_yaw.pop_front());
        end
        if (setup_done && !setup_prev) setup_cyc = cyc;
        wrt_prev = wrt;
        vld_prev = vld;
        setup_prev = setup_done;
    end

    initial begin
        repeat (3) tick();
        check("rst_wrt", wrt, 0);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_yaw", yaw_rt, 16'h0000);
        check("rst_vld", vld, 0);
        check("rst_setup", setup_done, 0);

        exp_cmd.push_back(CMD_INT_EN);
        exp_cmd.push_back(CMD_GYRO_ODR);
        exp_cmd.push_back(CMD_ROUND);
        rst_n = 1;
        rel = cyc;
        repeat (100) tick();
        pulse_done();
        wait_cnt("cfg_wrts", 3, 0, 500);
        check("pwr_lat", wrt_log[0] - rel, 255);
        check("cfg2_gap", wrt_log[1] - wrt_log[0], 40);
        check("cfg3_gap", wrt_log[2] - wrt_log[1], 40);
        wait_setup("setup_to");
        check("setup_lat", setup_cyc - wrt_log[2], 40);

        repeat (100) tick();
        pulse_done();
        repeat (20) tick();
        check("idle_quiet", wrt_log.size(), 3);
        check("idle_yaw", yaw_rt, 16'h0000);

        rdq.push_back(8'h34); rdq.push_back(8'h12);
        exp_cmd.push_back(CMD_YAWL); exp_cmd.push_back(CMD_YAWH);
        exp_yaw.push_back(16'h1234);
        INT = 1;
        ic = cyc;
        wait_cnt("rd1_wrt", 4, 0, 20);
        INT = 0;
        check("int_lat", wrt_log[3] - ic, 3);
        wait_cnt("rd1_vld", 5, 1, 200);
        check("rd1_gap", wrt_log[4] - wrt_log[3], 40);
        check("vld_lat", vld_log[0] - wrt_log[4], 40);
        check("yaw1", yaw_rt, 16'h1234);
        repeat (60) tick();
        check("no_reread", wrt_log.size(), 5);

        rdq.push_back(8'h78); rdq.push_back(8'h56); rdq.push_back(8'hBC); rdq.push_back(8'h9A);
        repeat (2) begin
            exp_cmd.push_back(CMD_YAWL); exp_cmd.push_back(CMD_YAWH);
        end
        exp_yaw.push_back(16'h5678); exp_yaw.push_back(16'h9ABC);
        INT = 1;
        wait_cnt("hold_vld", 9, 3, 400);
        INT = 0;
        check("hold_gap", wrt_log[7] - vld_log[1], HOLD + 2);
        repeat (60) tick();
        check("hold_stop", wrt_log.size(), 9);
        check("yaw3", yaw_rt, 16'h9ABC);

        rdq.push_back(8'hEF); rdq.push_back(8'hCD);
        exp_cmd.push_back(CMD_YAWL); exp_cmd.push_back(CMD_YAWH);
        exp_yaw.push_back(16'hCDEF);
        INT = 1;
        wait_cnt("pulse_wrt", 10, 3, 20);
        INT = 0;
        repeat (10) tick();
        INT = 1;
        repeat (3) tick();
        INT = 0;
        wait_cnt("pulse_vld", 11, 4, 200);
        repeat (60) tick();
        check("pulse_wrts", wrt_log.size(), 11);
        check("pulse_vlds", vld_log.size(), 4);

        rdq.push_back(8'h11); rdq.push_back(8'h22);
        exp_cmd.push_back(CMD_YAWL); exp_cmd.push_back(CMD_YAWH);
        INT = 1;
        wait_cnt("rdh_wrt1", 12, 4, 20);
        INT = 0;
        wait_cnt("rdh_wrt2", 13, 4, 100);
        repeat (10) tick();
        #2 rst_n = 0;
        #1;
        check("arst_wrt", wrt, 0);
        check("arst_cmd", cmd, 16'h0000);
        check("arst_yaw", yaw_rt, 16'h0000);
        check("arst_vld", vld, 0);
        check("arst_setup", setup_done, 0);
        rdq.delete();
        exp_cmd.delete();
        exp_cmd.push_back(CMD_INT_EN);
        exp_cmd.push_back(CMD_GYRO_ODR);
        exp_cmd.push_back(CMD_ROUND);
        setup_cyc = -1;
        nw = wrt_log.size();
        nv = vld_log.size();
        repeat (5) tick();
        rst_n = 1;
        rel = cyc;
        wait_cnt("rst_cfg", nw + 3, 0, 500);
        check("rst_pwr_lat", wrt_log[nw] - rel, 255);
        wait_setup("rst_setup_to");
        check("rst_setup_lat", setup_cyc - wrt_log[nw + 2], 40);
        check("no_vld_pre_setup", vld_log.size(), nv);
        check("cmd_q_empty", exp_cmd.size(), 0);
        check("yaw_q_empty", exp_yaw.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
